// File: rtl/lpb_pkg.sv
// Shared definitions for the lane pattern builder.
package lpb_pkg;

    // Build sequencing: idle, accepting lane writes, holding a finished record.
    typedef enum logic [1:0] {
        LPB_IDLE = 2'd0,
        LPB_FILL = 2'd1,
        LPB_HOLD = 2'd2
    } lpb_state_e;

endpackage

// File: rtl/lpb_lane_decoder.sv
// Turns an indexed lane number or the positional pointer into a one-hot
// lane enable, flagging out-of-range indices and exhausted positional slots.
module lpb_lane_decoder
    import lpb_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    localparam int unsigned IDX_W = $clog2(LANES)
) (
    input  logic             wr_pos_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [IDX_W-1:0] pos_ptr_i,
    input  logic             pos_done_i,
    output logic [LANES-1:0] lane_en_o,
    output logic             err_o
);

    // One extra bit so the range check works when LANES is a power of two.
    localparam logic [IDX_W:0] LANES_EXT = (IDX_W+1)'(LANES);

    logic [IDX_W-1:0] tgt;
    logic             bad;

    // Select target lane, classify the write, and expand to one-hot.
    always_comb begin
        lane_en_o = '0;
        tgt       = wr_pos_i ? pos_ptr_i : wr_idx_i;
        bad       = wr_pos_i ? pos_done_i : ({1'b0, wr_idx_i} >= LANES_EXT);
        if (!bad) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (tgt == IDX_W'(k)) lane_en_o[k] = 1'b1;
            end
        end
        err_o = bad;
    end

endmodule

// File: rtl/lane_pattern_builder.sv
// Assembles a packed LANES x LANE_W record from a default fill plus indexed
// or positional lane writes; hands the record off with valid/ready.
module lane_pattern_builder
    import lpb_pkg::*;
#(
    parameter  int unsigned LANES  = 4,
    parameter  int unsigned LANE_W = 64,
    localparam int unsigned IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [LANE_W-1:0]       default_i,
    input  logic                    wr_valid_i,
    input  logic                    wr_pos_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [LANE_W-1:0]       wr_data_i,
    input  logic                    wr_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*LANE_W-1:0] out_data_o,
    output logic [LANES-1:0]        out_mask_o,
    output logic                    err_o
);

    typedef logic [LANE_W-1:0] lane_t;

    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(LANES - 1);

    lpb_state_e       state_q;
    logic             out_valid_q;
    logic             err_q;
    logic [LANES-1:0] mask_q;
    logic [IDX_W-1:0] pos_ptr_q;
    logic             pos_done_q;
    lane_t            lanes_q [LANES];

    logic [LANES-1:0] dec_en;
    logic             dec_err;
    logic             start_acc;
    logic             wr_acc;
    logic [LANES-1:0] lane_we;

    lpb_lane_decoder #(
        .LANES(LANES)
    ) u_dec (
        .wr_pos_i  (wr_pos_i),
        .wr_idx_i  (wr_idx_i),
        .pos_ptr_i (pos_ptr_q),
        .pos_done_i(pos_done_q),
        .lane_en_o (dec_en),
        .err_o     (dec_err)
    );

    // Start is taken in IDLE/FILL, or in HOLD only together with the handshake;
    // a start in the same cycle as a write takes priority and drops the write.
    always_comb begin
        start_acc = start_i && ((state_q == LPB_IDLE) || (state_q == LPB_FILL) ||
                                ((state_q == LPB_HOLD) && out_ready_i));
        wr_acc    = (state_q == LPB_FILL) && wr_valid_i && !start_i;
        lane_we   = (wr_acc && !dec_err) ? dec_en : '0;
    end

    // Build sequencer: state, handshake, mask, positional pointer, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LPB_IDLE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            mask_q      <= '0;
            pos_ptr_q   <= PTR_INIT;
            pos_done_q  <= 1'b0;
        end else if (start_acc) begin
            state_q     <= LPB_FILL;
            out_valid_q <= 1'b0;
            mask_q      <= '0;
            pos_ptr_q   <= PTR_INIT;
            pos_done_q  <= 1'b0;
        end else begin
            case (state_q)
                LPB_IDLE: ;
                LPB_FILL: begin
                    if (wr_acc) begin
                        if (dec_err) begin
                            err_q <= 1'b1;
                        end else begin
                            mask_q <= mask_q | dec_en;
                            if (wr_pos_i) begin
                                if (pos_ptr_q == '0) pos_done_q <= 1'b1;
                                else                 pos_ptr_q  <= pos_ptr_q - IDX_W'(1);
                            end
                        end
                        // Last completes the build even when its own write was dropped.
                        if (wr_last_i) begin
                            state_q     <= LPB_HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                LPB_HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= LPB_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= LPB_IDLE;
            endcase
        end
    end

    // Lane storage: default fill on start, otherwise per-lane write enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < LANES; k++) lanes_q[k] <= '0;
        end else if (start_acc) begin
            for (int unsigned k = 0; k < LANES; k++) lanes_q[k] <= default_i;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lane_we[k]) lanes_q[k] <= wr_data_i;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign out_data_o[g*LANE_W +: LANE_W] = lanes_q[g];
    end

    assign out_valid_o = out_valid_q;
    assign out_mask_o  = mask_q;
    assign err_o       = err_q;

endmodule
